// File: rtl/frogger_pkg.sv
// Shared types and screen constants for the frog sprite, its colour mapper and hazard logic.
// Also holds the single-axis step-with-clamp helper used by the hop sequencer.
package frogger_pkg;

    typedef enum logic [1:0] {IDLE, HOP, COOL, DEAD} hop_state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam logic [9:0] X_MIN   = 10'd0;
    localparam logic [9:0] X_MAX   = 10'd639;
    localparam logic [9:0] Y_MIN   = 10'd0;
    localparam logic [9:0] Y_MAX   = 10'd479;
    localparam logic [9:0] X_START = 10'd320;
    localparam logic [9:0] Y_START = 10'd464;
    localparam logic [9:0] SIZE    = 10'd8;
    localparam logic [9:0] STEP_PX = 10'd8;

    localparam int HOP_FRAMES  = 4;
    localparam int COOL_FRAMES = 2;
    localparam int DEAD_FRAMES = 60;

    localparam int MAX_FRAMES = (HOP_FRAMES > COOL_FRAMES)
                              ? ((HOP_FRAMES > DEAD_FRAMES) ? HOP_FRAMES : DEAD_FRAMES)
                              : ((COOL_FRAMES > DEAD_FRAMES) ? COOL_FRAMES : DEAD_FRAMES);
    localparam int CNT_W = $clog2(MAX_FRAMES + 1);

    // The 11-bit intermediate keeps an underflow below 0 visible in bit 10 instead of wrapping.
    function automatic logic [9:0] step_clamp(input logic [9:0] pos, input logic neg,
                                              input logic [9:0] lo, input logic [9:0] hi);
        logic [10:0] t;
        logic [9:0]  r;
        if (neg) begin
            t = {1'b0, pos} - {1'b0, STEP_PX};
            r = (t[10] || (t < {1'b0, lo})) ? lo : t[9:0];
        end else begin
            t = {1'b0, pos} + {1'b0, STEP_PX};
            r = (t > {1'b0, hi}) ? hi : t[9:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/frog_key_arb.sv
// Fixed-priority key arbiter (up > down > left > right) with a release-to-re-arm flag,
// so a held key produces exactly one hop request.
module frog_key_arb
    import frogger_pkg::*;
(
    input  logic frame_clk,
    input  logic Reset,
    input  logic up,
    input  logic down,
    input  logic left,
    input  logic right,
    input  logic accept,
    input  logic disarm,
    output logic req,
    output dir_t dir
);

    logic armed_q, armed_d;
    logic any_key;

    assign any_key = up | down | left | right;
    assign req     = armed_q & any_key;

    always_comb begin
        dir = DIR_UP;
        if (up)         dir = DIR_UP;
        else if (down)  dir = DIR_DOWN;
        else if (left)  dir = DIR_LEFT;
        else if (right) dir = DIR_RIGHT;
    end

    // A respawn disarms even if all keys happen to be low on that edge.
    always_comb begin
        armed_d = armed_q;
        if (!any_key)          armed_d = 1'b1;
        if (accept || disarm)  armed_d = 1'b0;
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) armed_q <= 1'b1;
        else        armed_q <= armed_d;
    end

endmodule

// File: rtl/frog_hop_ctrl.sv
// Per-frame frog movement sequencer: turns one accepted key press into a clamped
// fixed-length hop, then cools down; a kill runs a timed death and respawn.
module frog_hop_ctrl
    import frogger_pkg::*;
(
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       kill,
    output logic [9:0] FrogX,
    output logic [9:0] FrogY,
    output logic [9:0] FrogS,
    output logic       hopping,
    output logic       dead,
    output logic [3:0] lives_lost,
    output hop_state_t dbg_state_o
);

    hop_state_t       state_q, state_d;
    dir_t             dir_q, dir_d, arb_dir;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic [3:0]       lives_q, lives_d;
    logic             hopping_q, dead_q;
    logic             req, accept, disarm;

    frog_key_arb u_arb (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .accept    (accept),
        .disarm    (disarm),
        .req       (req),
        .dir       (arb_dir)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        lives_d = lives_q;
        accept  = 1'b0;
        disarm  = 1'b0;

        // Kill pre-empts every other action, including the final hop step.
        if (kill && state_q != DEAD) begin
            state_d = DEAD;
            cnt_d   = '0;
            if (lives_q != 4'd15) lives_d = lives_q + 4'd1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        accept  = 1'b1;
                        dir_d   = arb_dir;
                        cnt_d   = '0;
                        state_d = HOP;
                    end
                end
                HOP: begin
                    case (dir_q)
                        DIR_UP:    y_d = step_clamp(y_q, 1'b1, Y_MIN + SIZE, Y_MAX - SIZE);
                        DIR_DOWN:  y_d = step_clamp(y_q, 1'b0, Y_MIN + SIZE, Y_MAX - SIZE);
                        DIR_LEFT:  x_d = step_clamp(x_q, 1'b1, X_MIN + SIZE, X_MAX - SIZE);
                        default:   x_d = step_clamp(x_q, 1'b0, X_MIN + SIZE, X_MAX - SIZE);
                    endcase
                    if (cnt_q == CNT_W'(HOP_FRAMES - 1)) begin
                        cnt_d   = '0;
                        state_d = (COOL_FRAMES == 0) ? IDLE : COOL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                COOL: begin
                    if (cnt_q == CNT_W'(COOL_FRAMES - 1)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == CNT_W'(DEAD_FRAMES - 1)) begin
                        cnt_d   = '0;
                        x_d     = X_START;
                        y_d     = Y_START;
                        disarm  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            dir_q     <= DIR_UP;
            cnt_q     <= '0;
            x_q       <= X_START;
            y_q       <= Y_START;
            lives_q   <= 4'd0;
            hopping_q <= 1'b0;
            dead_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            lives_q   <= lives_d;
            hopping_q <= (state_d == HOP);
            dead_q    <= (state_d == DEAD);
        end
    end

    assign FrogX       = x_q;
    assign FrogY       = y_q;
    assign FrogS       = SIZE;
    assign hopping     = hopping_q;
    assign dead        = dead_q;
    assign lives_lost  = lives_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Directed bench for frog_hop_ctrl: hop timing, priority, clamping, cooldown,
// death/respawn, lives saturation and asynchronous reset mid-hop.
module tb_frog_hop_ctrl;
    import frogger_pkg::*;

    logic       frame_clk;
    logic       Reset;
    logic       up, down, left, right, kill;
    logic [9:0] FrogX, FrogY, FrogS;
    logic       hopping, dead;
    logic [3:0] lives_lost;
    hop_state_t dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    frog_hop_ctrl dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .up          (up),
        .down        (down),
        .left        (left),
        .right       (right),
        .kill        (kill),
        .FrogX       (FrogX),
        .FrogY       (FrogY),
        .FrogS       (FrogS),
        .hopping     (hopping),
        .dead        (dead),
        .lives_lost  (lives_lost),
        .dbg_state_o (dbg_state)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; kill = 1'b0;
        Reset = 1'b0;
        tick(2);
        Reset = 1'b1;
    endtask

    // One complete left hop from IDLE: accept, four moves, release, cooldown.
    task automatic hop_left();
        left = 1'b1;
        tick(5);
        left = 1'b0;
        tick(3);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({FrogX, FrogY, FrogS, hopping, dead, lives_lost} !==
            {10'd320, 10'd464, 10'd8, 1'b0, 1'b0, 4'd0}) begin
            miscompares++;
            $display("FAIL reset_vals: X=%0d Y=%0d S=%0d hop=%0b dead=%0b lives=%0d expected 320 464 8 0 0 0",
                     FrogX, FrogY, FrogS, hopping, dead, lives_lost);
        end
        vectors++;
        if (dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_state: state=%0d expected %0d", dbg_state, IDLE);
        end
    endtask

    task automatic test_hop_up();
        do_reset();
        up = 1'b1;
        tick();
        vectors++;
        if ({hopping, FrogY} !== {1'b1, 10'd464}) begin
            miscompares++;
            $display("FAIL up_accept: hop=%0b Y=%0d expected 1 464", hopping, FrogY);
        end
        for (int i = 0; i < 4; i++) begin
            logic [9:0] exp_y;
            exp_y = 10'(464 - 8 * (i + 1));
            tick();
            vectors++;
            if (FrogY !== exp_y) begin
                miscompares++;
                $display("FAIL up_step%0d: Y=%0d expected %0d", i + 1, FrogY, exp_y);
            end
        end
        tick(5);
        vectors++;
        if ({FrogX, FrogY, hopping} !== {10'd320, 10'd432, 1'b0}) begin
            miscompares++;
            $display("FAIL up_held_once: X=%0d Y=%0d hop=%0b expected 320 432 0", FrogX, FrogY, hopping);
        end
        up = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        do_reset();
        up = 1'b1; left = 1'b1;
        tick(5);
        vectors++;
        if ({FrogX, FrogY} !== {10'd320, 10'd432}) begin
            miscompares++;
            $display("FAIL prio_up_wins: X=%0d Y=%0d expected 320 432", FrogX, FrogY);
        end
        up = 1'b0; left = 1'b0;
        tick(3);
        left = 1'b1;
        tick();
        vectors++;
        if (hopping !== 1'b1) begin
            miscompares++;
            $display("FAIL left_accept: hop=%0b expected 1", hopping);
        end
        for (int i = 0; i < 4; i++) begin
            logic [9:0] exp_x;
            exp_x = 10'(320 - 8 * (i + 1));
            tick();
            vectors++;
            if ({FrogX, FrogY} !== {exp_x, 10'd432}) begin
                miscompares++;
                $display("FAIL left_step%0d: X=%0d Y=%0d expected %0d 432", i + 1, FrogX, FrogY, exp_x);
            end
        end
        left = 1'b0;
        tick(3);
    endtask

    task automatic test_clamp_left();
        logic [9:0] exp_x [4];
        exp_x[0] = 10'd24; exp_x[1] = 10'd16; exp_x[2] = 10'd8; exp_x[3] = 10'd8;
        do_reset();
        repeat (9) hop_left();
        vectors++;
        if (FrogX !== 10'd32) begin
            miscompares++;
            $display("FAIL clamp_setup: X=%0d expected 32", FrogX);
        end
        left = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (FrogX !== exp_x[i]) begin
                miscompares++;
                $display("FAIL clamp_left%0d: X=%0d expected %0d", i + 1, FrogX, exp_x[i]);
            end
        end
        left = 1'b0;
        tick(3);
        hop_left();
        vectors++;
        if (FrogX !== 10'd8) begin
            miscompares++;
            $display("FAIL clamp_no_wrap: X=%0d expected 8", FrogX);
        end
    endtask

    task automatic test_clamp_down();
        do_reset();
        down = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (FrogY !== 10'd471) begin
                miscompares++;
                $display("FAIL clamp_down%0d: Y=%0d expected 471", i + 1, FrogY);
            end
        end
        down = 1'b0;
        tick(3);
    endtask

    task automatic test_cool_ignore();
        do_reset();
        up = 1'b1;
        tick(5);
        up = 1'b0;
        tick();
        up = 1'b1;
        tick();
        vectors++;
        if ({hopping, FrogY, dbg_state} !== {1'b0, 10'd432, IDLE}) begin
            miscompares++;
            $display("FAIL cool_ignored: hop=%0b Y=%0d state=%0d expected 0 432 %0d",
                     hopping, FrogY, dbg_state, IDLE);
        end
        tick();
        vectors++;
        if (hopping !== 1'b1) begin
            miscompares++;
            $display("FAIL after_cool_accept: hop=%0b expected 1", hopping);
        end
        tick(4);
        vectors++;
        if (FrogY !== 10'd400) begin
            miscompares++;
            $display("FAIL after_cool_hop: Y=%0d expected 400", FrogY);
        end
        up = 1'b0;
        tick(3);
    endtask

    task automatic test_kill();
        do_reset();
        up = 1'b1;
        tick(2);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        vectors++;
        if ({dead, hopping, FrogY, lives_lost, dbg_state} !== {1'b1, 1'b0, 10'd456, 4'd1, DEAD}) begin
            miscompares++;
            $display("FAIL kill_entry: dead=%0b hop=%0b Y=%0d lives=%0d state=%0d expected 1 0 456 1 %0d",
                     dead, hopping, FrogY, lives_lost, dbg_state, DEAD);
        end
        tick(9);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        tick(48);
        tick();
        vectors++;
        if ({dead, FrogY, lives_lost} !== {1'b1, 10'd456, 4'd1}) begin
            miscompares++;
            $display("FAIL dead_hold: dead=%0b Y=%0d lives=%0d expected 1 456 1", dead, FrogY, lives_lost);
        end
        tick();
        vectors++;
        if ({dead, FrogX, FrogY, dbg_state} !== {1'b0, 10'd320, 10'd464, IDLE}) begin
            miscompares++;
            $display("FAIL respawn: dead=%0b X=%0d Y=%0d state=%0d expected 0 320 464 %0d",
                     dead, FrogX, FrogY, dbg_state, IDLE);
        end
        tick(3);
        vectors++;
        if ({hopping, FrogY} !== {1'b0, 10'd464}) begin
            miscompares++;
            $display("FAIL respawn_held_key: hop=%0b Y=%0d expected 0 464", hopping, FrogY);
        end
        up = 1'b0;
        tick();
        up = 1'b1;
        tick();
        vectors++;
        if (hopping !== 1'b1) begin
            miscompares++;
            $display("FAIL respawn_rearm: hop=%0b expected 1", hopping);
        end
        up = 1'b0;
        tick(7);
    endtask

    task automatic test_lives_saturate();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] exp_l;
            exp_l = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            kill = 1'b1;
            tick();
            kill = 1'b0;
            vectors++;
            if (lives_lost !== exp_l) begin
                miscompares++;
                $display("FAIL lives_%0d: lives=%0d expected %0d", i + 1, lives_lost, exp_l);
            end
            tick(60);
        end
    endtask

    task automatic test_reset_midhop();
        do_reset();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        tick(61);
        right = 1'b1;
        tick(2);
        vectors++;
        if ({FrogX, hopping, lives_lost} !== {10'd328, 1'b1, 4'd1}) begin
            miscompares++;
            $display("FAIL midhop_setup: X=%0d hop=%0b lives=%0d expected 328 1 1", FrogX, hopping, lives_lost);
        end
        #2;
        Reset = 1'b0;
        #1;
        vectors++;
        if ({FrogX, FrogY, hopping, dead, lives_lost, dbg_state} !==
            {10'd320, 10'd464, 1'b0, 1'b0, 4'd0, IDLE}) begin
            miscompares++;
            $display("FAIL async_reset: X=%0d Y=%0d hop=%0b dead=%0b lives=%0d state=%0d expected 320 464 0 0 0 %0d",
                     FrogX, FrogY, hopping, dead, lives_lost, dbg_state, IDLE);
        end
        right = 1'b0;
        #1;
        Reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_hop_up();
        test_priority();
        test_clamp_left();
        test_clamp_down();
        test_cool_ignore();
        test_kill();
        test_lives_saturate();
        test_reset_midhop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
